v850_idecode: RTL and testbench
===============================

# v850_idecode

Instruction decode stage of the V850 core, directly downstream of the instruction fetcher. It accepts one fetched instruction per cycle together with its PC and halfword length. It classifies the format, extracts register numbers and a sign/zero-extended immediate, and registers the result for the execute stage. It holds output under execute backpressure, inserts a one-cycle bubble on load-use hazards, and drops its contents on a pipeline flush.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- inst_valid_i  in  1  fetch stage presents an instruction.
- inst_i  in  64  instruction, first halfword in [15:0].
- pc_i  in  25  byte address of the instruction.
- inst_len_i  in  3  length in halfwords (1..4).
- inst_ready_o  out  1  decode accepts the instruction this cycle.
- flush_i  in  1  discard all held state (branch redirect).
- ex_ready_i  in  1  execute stage consumes the decoded instruction.
- dec_valid_o  out  1  decoded outputs are valid.
- pc_o  out  25  registered pc_i.
- len_o  out  3  registered inst_len_i.
- op_class_o  out  4  format class (see Operation).
- opcode_o  out  6  inst[10:5].
- reg1_o  out  5  inst[4:0].
- reg2_o  out  5  inst[15:11].
- cond_o  out  4  inst[3:0]; meaningful for BCOND only.
- imm_o  out  32  extended immediate or displacement.
- illegal_o  out  1  encoding/length mismatch.

## Operation
- Classification of inst_i is combinational. Precedence is first match:
  - inst[10:6]=11110: JUMP(7); imm = sext({inst[5:0],inst[31:17],1'b0}).
  - inst[10:6]=11100: LOAD32(5); imm = sext(inst[31:16]).
  - inst[10:6]=11101: STORE32(6); imm = sext(inst[31:16]).
  - inst[10:6]=11111: EXT(8); imm = inst[47:16].
  - inst[10:8]=110: IMM16(4); imm = sext(inst[31:16]).
  - inst[10:7]=1011: BCOND(3); imm = sext({inst[15:11],inst[6:4],1'b0}).
  - inst[10:8]=010: IMM5(1); imm = sext(inst[4:0]).
  - inst[10:8]=011: SLDST(2); imm = zext(inst[6:0]).
  - Otherwise: REG16(0); imm = 0.
- Required lengths:
  - REG16, IMM5, SLDST, BCOND: 1.
  - JUMP, LOAD32, STORE32, IMM16: 2.
  - EXT: 3 or 4.
- On a length mismatch: op_class = 15, illegal = 1, imm = 0. The instruction is still passed downstream.
- Output register:
  - Loads when inst_valid_i && inst_ready_o.
  - Holds unchanged while dec_valid_o && !ex_ready_i.
  - inst_ready_o = !flush_i && !bubble_pending && (!dec_valid_o || ex_ready_i).
- Load-use interlock:
  - Tracking register ld_dst is set to reg2_o when a LOAD32 with reg2≠0 leaves the stage (dec_valid_o && ex_ready_i). Otherwise it is cleared to 0 on each transfer.
  - If the incoming valid instruction has reg1 or reg2 equal to a nonzero ld_dst, the stage asserts bubble_pending for exactly one cycle. During that cycle inst_ready_o = 0 and dec_valid_o = 0. ld_dst is then cleared.
- Flush: next cycle dec_valid_o = 0, bubble_pending = 0, ld_dst = 0. inst_ready_o = 0 during the flush cycle.

## Timing
- Reset values: all outputs 0 (dec_valid_o = 0, inst_ready_o = 0 during reset, imm_o = 0, op_class_o = 0). Internal ld_dst = 0 and bubble_pending = 0.
- Latency: 1 cycle from accepted instruction to dec_valid_o.
- Throughput: 1 instruction/cycle when ex_ready_i is held high and there are no hazards.
- Backpressure: outputs are stable while dec_valid_o && !ex_ready_i. A new instruction is accepted in the same cycle the old one leaves.
- Flush has priority over accept, hold and bubble.
- Reset asserted mid-operation: all state returns to reset values on the next edge.
- inst_valid_i low: no state change except a transfer-out (which clears dec_valid_o) and bubble expiry.

## Test plan
- ADD r3,r5 (inst = 0x29C3, len 1, pc 0x100), ex_ready high:
  - Next cycle: dec_valid = 1, op_class = 0, reg1 = 3, reg2 = 5, imm = 0, pc_o = 0x100.
- MOVEA (inst = 0xFFF03E20, len 2):
  - op_class = 4, reg2 = 7, imm = 0xFFFFFFF0.
  - Same encoding with len 1: op_class = 15, illegal = 1.
- LD.W (0x00002722, len 2) followed by ADD r4,r6 (0x31C4):
  - The load transfers out.
  - One cycle with inst_ready = 0 and dec_valid = 0.
  - Then ADD is decoded with reg1 = 4.
  - The same sequence with the load's reg2 = 0 gives no bubble.
- BR (0xFDE5, len 1):
  - op_class = 3, cond = 5, imm = 0xFFFFFFFC.
  - JR (0x00100780, len 2): op_class = 7, imm = 0x00000010.
- Hold ex_ready low for 3 cycles with a valid instruction pending:
  - Outputs are unchanged and inst_ready = 0.
  - Raise ex_ready: the pending instruction transfers and the new one is accepted the same cycle.
  - Assert flush with dec_valid high: next cycle dec_valid = 0.

Source files
------------

// File: rtl/v850_idecode.sv
// ---------------------------------------------------------------------------
// v850_idecode
//
// Instruction decode stage of the V850 core, sitting directly after the
// instruction fetcher. One fetched instruction per cycle is classified into
// a format class. Register numbers and an extended immediate are extracted,
// checked against the halfword length, and registered for the execute stage.
//
// The stage holds its outputs while execute applies backpressure. It inserts
// a one-cycle bubble when an instruction consumes the destination of a load
// that has just left the stage. A flush drops everything it holds.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   inst_valid_i  fetch presents an instruction
//   inst_i        instruction, first halfword in [15:0]
//   pc_i          byte address of the instruction
//   inst_len_i    instruction length in halfwords (1..4)
//   inst_ready_o  decode accepts the presented instruction this cycle
//   flush_i       discard all held state (branch redirect)
//   ex_ready_i    execute consumes the decoded instruction
//   dec_valid_o   decoded outputs are valid
//   pc_o, len_o   registered pc_i / inst_len_i
//   op_class_o    format class, 15 when the length does not fit the format
//   opcode_o      inst[10:5]
//   reg1_o        inst[4:0]
//   reg2_o        inst[15:11]
//   cond_o        inst[3:0], meaningful for BCOND only
//   imm_o         extended immediate or displacement
//   illegal_o     encoding/length mismatch
// ---------------------------------------------------------------------------
module v850_idecode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid_i,
    input  logic [63:0] inst_i,
    input  logic [24:0] pc_i,
    input  logic [2:0]  inst_len_i,
    output logic        inst_ready_o,
    input  logic        flush_i,
    input  logic        ex_ready_i,
    output logic        dec_valid_o,
    output logic [24:0] pc_o,
    output logic [2:0]  len_o,
    output logic [3:0]  op_class_o,
    output logic [5:0]  opcode_o,
    output logic [4:0]  reg1_o,
    output logic [4:0]  reg2_o,
    output logic [3:0]  cond_o,
    output logic [31:0] imm_o,
    output logic        illegal_o
);

    localparam logic [3:0] CLS_REG16   = 4'd0;
    localparam logic [3:0] CLS_IMM5    = 4'd1;
    localparam logic [3:0] CLS_SLDST   = 4'd2;
    localparam logic [3:0] CLS_BCOND   = 4'd3;
    localparam logic [3:0] CLS_IMM16   = 4'd4;
    localparam logic [3:0] CLS_LOAD32  = 4'd5;
    localparam logic [3:0] CLS_STORE32 = 4'd6;
    localparam logic [3:0] CLS_JUMP    = 4'd7;
    localparam logic [3:0] CLS_EXT     = 4'd8;
    localparam logic [3:0] CLS_ILLEGAL = 4'd15;

    // Registered state
    logic        dec_valid_r;
    logic        bubble_r;
    logic [4:0]  ld_dst_r;
    logic [24:0] pc_r;
    logic [2:0]  len_r;
    logic [3:0]  op_class_r;
    logic [5:0]  opcode_r;
    logic [4:0]  reg1_r;
    logic [4:0]  reg2_r;
    logic [3:0]  cond_r;
    logic [31:0] imm_r;
    logic        illegal_r;

    // Combinational decode and control
    logic [3:0]  raw_cls_s;
    logic [31:0] raw_imm_s;
    logic        len_ok_s;
    logic [3:0]  dec_cls_s;
    logic [31:0] dec_imm_s;
    logic        inst_ready_s;
    logic        accept_s;
    logic        out_fire_s;
    logic [4:0]  ld_next_s;
    logic        hazard_s;

    // The upper halfword of a 64-bit fetch carries no decoded field.
    logic        unused_hi_s;
    assign unused_hi_s = ^inst_i[63:48];

    // Format classification, first match wins, with raw immediate extraction
    always_comb begin
        raw_cls_s = CLS_REG16;
        raw_imm_s = 32'd0;
        if (inst_i[10:6] == 5'b11110) begin
            raw_cls_s = CLS_JUMP;
            raw_imm_s = {{10{inst_i[5]}}, inst_i[5:0], inst_i[31:17], 1'b0};
        end else if (inst_i[10:6] == 5'b11100) begin
            raw_cls_s = CLS_LOAD32;
            raw_imm_s = {{16{inst_i[31]}}, inst_i[31:16]};
        end else if (inst_i[10:6] == 5'b11101) begin
            raw_cls_s = CLS_STORE32;
            raw_imm_s = {{16{inst_i[31]}}, inst_i[31:16]};
        end else if (inst_i[10:6] == 5'b11111) begin
            raw_cls_s = CLS_EXT;
            raw_imm_s = inst_i[47:16];
        end else if (inst_i[10:8] == 3'b110) begin
            raw_cls_s = CLS_IMM16;
            raw_imm_s = {{16{inst_i[31]}}, inst_i[31:16]};
        end else if (inst_i[10:7] == 4'b1011) begin
            raw_cls_s = CLS_BCOND;
            raw_imm_s = {{23{inst_i[15]}}, inst_i[15:11], inst_i[6:4], 1'b0};
        end else if (inst_i[10:8] == 3'b010) begin
            raw_cls_s = CLS_IMM5;
            raw_imm_s = {{27{inst_i[4]}}, inst_i[4:0]};
        end else if (inst_i[10:8] == 3'b011) begin
            raw_cls_s = CLS_SLDST;
            raw_imm_s = {25'd0, inst_i[6:0]};
        end else begin
            raw_cls_s = CLS_REG16;
            raw_imm_s = 32'd0;
        end
    end

    // Length check: a mismatch still flows downstream, tagged illegal
    always_comb begin
        len_ok_s = 1'b0;
        case (raw_cls_s)
            CLS_REG16, CLS_IMM5, CLS_SLDST, CLS_BCOND:
                len_ok_s = (inst_len_i == 3'd1);
            CLS_JUMP, CLS_LOAD32, CLS_STORE32, CLS_IMM16:
                len_ok_s = (inst_len_i == 3'd2);
            CLS_EXT:
                len_ok_s = (inst_len_i == 3'd3) || (inst_len_i == 3'd4);
            default:
                len_ok_s = 1'b0;
        endcase
        if (len_ok_s) begin
            dec_cls_s = raw_cls_s;
            dec_imm_s = raw_imm_s;
        end else begin
            dec_cls_s = CLS_ILLEGAL;
            dec_imm_s = 32'd0;
        end
    end

    // Handshake and load-use detection
    always_comb begin
        out_fire_s   = dec_valid_r && ex_ready_i;
        inst_ready_s = rst_n && !flush_i && !bubble_r && (!dec_valid_r || ex_ready_i);
        accept_s     = inst_valid_i && inst_ready_s;
        // Value the load tracker takes at this edge. A load leaving now is
        // visible to the instruction accepted in the same cycle, so the
        // hazard is caught without stalling the fetch side first.
        if (out_fire_s) begin
            if ((op_class_r == CLS_LOAD32) && (reg2_r != 5'd0)) begin
                ld_next_s = reg2_r;
            end else begin
                ld_next_s = 5'd0;
            end
        end else if (bubble_r) begin
            ld_next_s = 5'd0;
        end else begin
            ld_next_s = ld_dst_r;
        end
        hazard_s = accept_s && (ld_next_s != 5'd0) &&
                   ((inst_i[4:0] == ld_next_s) || (inst_i[15:11] == ld_next_s));
    end

    // Control state: valid flag, bubble and load tracker
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_valid_r <= 1'b0;
            bubble_r    <= 1'b0;
            ld_dst_r    <= 5'd0;
        end else if (flush_i) begin
            dec_valid_r <= 1'b0;
            bubble_r    <= 1'b0;
            ld_dst_r    <= 5'd0;
        end else begin
            ld_dst_r <= ld_next_s;
            if (bubble_r) begin
                // The hazarding instruction already sits in the output
                // register; it becomes visible once the bubble has expired.
                bubble_r    <= 1'b0;
                dec_valid_r <= 1'b1;
            end else if (accept_s) begin
                bubble_r    <= hazard_s;
                dec_valid_r <= !hazard_s;
            end else if (out_fire_s) begin
                dec_valid_r <= 1'b0;
            end else begin
                dec_valid_r <= dec_valid_r;
            end
        end
    end

    // Decoded payload register, loaded only on accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r       <= 25'd0;
            len_r      <= 3'd0;
            op_class_r <= 4'd0;
            opcode_r   <= 6'd0;
            reg1_r     <= 5'd0;
            reg2_r     <= 5'd0;
            cond_r     <= 4'd0;
            imm_r      <= 32'd0;
            illegal_r  <= 1'b0;
        end else if (accept_s) begin
            pc_r       <= pc_i;
            len_r      <= inst_len_i;
            op_class_r <= dec_cls_s;
            opcode_r   <= inst_i[10:5];
            reg1_r     <= inst_i[4:0];
            reg2_r     <= inst_i[15:11];
            cond_r     <= inst_i[3:0];
            imm_r      <= dec_imm_s;
            illegal_r  <= !len_ok_s;
        end else begin
            pc_r       <= pc_r;
        end
    end

    assign inst_ready_o = inst_ready_s;
    assign dec_valid_o  = dec_valid_r;
    assign pc_o         = pc_r;
    assign len_o        = len_r;
    assign op_class_o   = op_class_r;
    assign opcode_o     = opcode_r;
    assign reg1_o       = reg1_r;
    assign reg2_o       = reg2_r;
    assign cond_o       = cond_r;
    assign imm_o        = imm_r;
    assign illegal_o    = illegal_r;

endmodule

// File: tb/tb_v850_idecode.sv
// ---------------------------------------------------------------------------
// tb_v850_idecode
//
// Directed steps for reset, decode examples, the load-use bubble,
// backpressure, flush and mid-run reset. These are followed by a random
// phase in which every instruction leaving the stage is compared against a
// transaction-level reference decoder fed from the accepted inputs.
// ---------------------------------------------------------------------------
module tb_v850_idecode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic [63:0] inst_i = 64'd0;
    logic [24:0] pc_i = 25'd0;
    logic [2:0]  inst_len_i = 3'd0;
    logic        inst_ready_o;
    logic        flush_i = 1'b0;
    logic        ex_ready_i = 1'b0;
    logic        dec_valid_o;
    logic [24:0] pc_o;
    logic [2:0]  len_o;
    logic [3:0]  op_class_o;
    logic [5:0]  opcode_o;
    logic [4:0]  reg1_o;
    logic [4:0]  reg2_o;
    logic [3:0]  cond_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    int n_chk = 0;
    int n_err = 0;

    v850_idecode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid_i (inst_valid_i),
        .inst_i       (inst_i),
        .pc_i         (pc_i),
        .inst_len_i   (inst_len_i),
        .inst_ready_o (inst_ready_o),
        .flush_i      (flush_i),
        .ex_ready_i   (ex_ready_i),
        .dec_valid_o  (dec_valid_o),
        .pc_o         (pc_o),
        .len_o        (len_o),
        .op_class_o   (op_class_o),
        .opcode_o     (opcode_o),
        .reg1_o       (reg1_o),
        .reg2_o       (reg2_o),
        .cond_o       (cond_o),
        .imm_o        (imm_o),
        .illegal_o    (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] w, input logic [24:0] pc,
                         input logic [2:0] len);
        inst_valid_i = v;
        inst_i       = w;
        pc_i         = pc;
        inst_len_i   = len;
    endtask

    // Reference decode from the format table, using integer arithmetic for
    // the sign extension. Packing: pc, len, class, opcode, reg1, reg2, cond,
    // imm, illegal.
    function automatic logic [84:0] ref_decode(input logic [63:0] w, input logic [24:0] pc,
                                               input logic [2:0] len);
        int     f5;
        int     f4;
        int     f3;
        int     cls;
        int     lo;
        int     hi;
        longint v;
        logic   ill;
        f5 = int'(w[10:6]);
        f4 = int'(w[10:7]);
        f3 = int'(w[10:8]);
        if (f5 == 30) begin
            cls = 7; lo = 2; hi = 2;
            v = longint'({w[5:0], w[31:17]}) * 2;
            if (v >= 2097152) v = v - 4194304;
        end else if (f5 == 28 || f5 == 29) begin
            cls = (f5 == 28) ? 5 : 6; lo = 2; hi = 2;
            v = longint'(w[31:16]);
            if (v >= 32768) v = v - 65536;
        end else if (f5 == 31) begin
            cls = 8; lo = 3; hi = 4;
            v = longint'(w[47:16]);
        end else if (f3 == 6) begin
            cls = 4; lo = 2; hi = 2;
            v = longint'(w[31:16]);
            if (v >= 32768) v = v - 65536;
        end else if (f4 == 11) begin
            cls = 3; lo = 1; hi = 1;
            v = longint'(w[15:11]) * 16 + longint'(w[6:4]) * 2;
            if (v >= 256) v = v - 512;
        end else if (f3 == 2) begin
            cls = 1; lo = 1; hi = 1;
            v = longint'(w[4:0]);
            if (v >= 16) v = v - 32;
        end else if (f3 == 3) begin
            cls = 2; lo = 1; hi = 1;
            v = longint'(w[6:0]);
        end else begin
            cls = 0; lo = 1; hi = 1;
            v = 0;
        end
        ill = 1'b0;
        if (int'(len) < lo || int'(len) > hi) begin
            cls = 15;
            v   = 0;
            ill = 1'b1;
        end
        return {pc, len, 4'(cls), w[10:5], w[4:0], w[15:11], w[3:0], 32'(v), ill};
    endfunction

    function automatic logic [84:0] dut_bundle();
        return {pc_o, len_o, op_class_o, opcode_o, reg1_o, reg2_o, cond_o, imm_o, illegal_o};
    endfunction

    logic [84:0] exp_q[$];
    logic [84:0] snap;
    logic        acc;
    logic        xfer;
    logic        stalled;
    logic        was_flush;
    logic [63:0] w;
    int          n_xfer;

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        ex_ready_i = 1'b1;
        drive(1'b1, 64'h29C3, 25'h100, 3'd1);
        cyc(); cyc();
        chk("rst_dec_valid", 96'(dec_valid_o), 96'd0);
        chk("rst_inst_ready", 96'(inst_ready_o), 96'd0);
        chk("rst_imm", 96'(imm_o), 96'd0);
        chk("rst_op_class", 96'(op_class_o), 96'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 96'(inst_ready_o), 96'd1);

        // ---------------- ADD r3,r5 ----------------
        cyc();
        drive(1'b1, 64'hFFF03E20, 25'h104, 3'd2);
        chk("add_valid", 96'(dec_valid_o), 96'd1);
        chk("add_bundle", 96'(dut_bundle()),
            96'({25'h100, 3'd1, 4'd0, 6'b001110, 5'd3, 5'd5, 4'd3, 32'd0, 1'b0}));

        // ---------------- MOVEA len 2, then len 1 ----------------
        cyc();
        drive(1'b1, 64'hFFF03E20, 25'h108, 3'd1);
        chk("movea_class", 96'(op_class_o), 96'd4);
        chk("movea_reg2", 96'(reg2_o), 96'd7);
        chk("movea_imm", 96'(imm_o), 96'hFFFFFFF0);
        chk("movea_illegal", 96'(illegal_o), 96'd0);
        cyc();
        drive(1'b1, 64'hFDE5, 25'h10C, 3'd1);
        chk("movea_len1_class", 96'(op_class_o), 96'd15);
        chk("movea_len1_illegal", 96'(illegal_o), 96'd1);
        chk("movea_len1_imm", 96'(imm_o), 96'd0);

        // ---------------- BR and JR ----------------
        cyc();
        drive(1'b1, 64'h00100780, 25'h110, 3'd2);
        chk("br_class", 96'(op_class_o), 96'd3);
        chk("br_cond", 96'(cond_o), 96'd5);
        chk("br_imm", 96'(imm_o), 96'hFFFFFFFC);
        cyc();
        drive(1'b0, 64'd0, 25'd0, 3'd1);
        chk("jr_class", 96'(op_class_o), 96'd7);
        chk("jr_imm", 96'(imm_o), 96'h10);
        cyc();
        chk("drained", 96'(dec_valid_o), 96'd0);

        // ---------------- load-use bubble ----------------
        drive(1'b1, 64'h00002722, 25'h200, 3'd2);
        cyc();
        chk("ld_class", 96'(op_class_o), 96'd5);
        drive(1'b1, 64'h31C4, 25'h204, 3'd1);
        #1;
        chk("ld_next_accept", 96'(inst_ready_o), 96'd1);
        cyc();
        drive(1'b0, 64'd0, 25'd0, 3'd1);
        #1;
        chk("bubble_dec_valid", 96'(dec_valid_o), 96'd0);
        chk("bubble_ready", 96'(inst_ready_o), 96'd0);
        cyc();
        chk("after_bubble_valid", 96'(dec_valid_o), 96'd1);
        chk("after_bubble_reg1", 96'(reg1_o), 96'd4);
        chk("after_bubble_pc", 96'(pc_o), 96'h204);
        cyc();
        chk("after_bubble_drain", 96'(dec_valid_o), 96'd0);

        // ---------------- load with reg2 = 0: no bubble ----------------
        drive(1'b1, 64'h00000722, 25'h300, 3'd2);
        cyc();
        drive(1'b1, 64'h31C4, 25'h304, 3'd1);
        cyc();
        drive(1'b0, 64'd0, 25'd0, 3'd1);
        #1;
        chk("nobubble_valid", 96'(dec_valid_o), 96'd1);
        chk("nobubble_reg1", 96'(reg1_o), 96'd4);
        chk("nobubble_ready", 96'(inst_ready_o), 96'd1);
        cyc();

        // ---------------- backpressure and flush ----------------
        drive(1'b1, 64'h29C3, 25'h400, 3'd1);
        cyc();
        ex_ready_i = 1'b0;
        drive(1'b1, 64'hFDE5, 25'h404, 3'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_ready", 96'(inst_ready_o), 96'd0);
            cyc();
            chk("stall_valid", 96'(dec_valid_o), 96'd1);
            chk("stall_bundle", 96'(dut_bundle()),
                96'({25'h400, 3'd1, 4'd0, 6'b001110, 5'd3, 5'd5, 4'd3, 32'd0, 1'b0}));
        end
        ex_ready_i = 1'b1;
        #1;
        chk("release_ready", 96'(inst_ready_o), 96'd1);
        cyc();
        drive(1'b0, 64'd0, 25'd0, 3'd1);
        ex_ready_i = 1'b0;
        chk("release_pc", 96'(pc_o), 96'h404);
        chk("release_class", 96'(op_class_o), 96'd3);
        chk("release_valid", 96'(dec_valid_o), 96'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_ready", 96'(inst_ready_o), 96'd0);
        cyc();
        flush_i = 1'b0;
        chk("flush_valid", 96'(dec_valid_o), 96'd0);

        // ---------------- reset mid-operation ----------------
        ex_ready_i = 1'b0;
        drive(1'b1, 64'hFFF03E20, 25'h500, 3'd2);
        cyc();
        chk("pre_rst_valid", 96'(dec_valid_o), 96'd1);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_valid", 96'(dec_valid_o), 96'd0);
        chk("mid_rst_pc", 96'(pc_o), 96'd0);
        chk("mid_rst_imm", 96'(imm_o), 96'd0);
        rst_n = 1'b1;
        drive(1'b0, 64'd0, 25'd0, 3'd1);
        cyc();

        // ---------------- random phase ----------------
        stalled = 1'b0;
        n_xfer  = 0;
        for (int i = 0; i < 3000; i++) begin
            w = {$urandom, $urandom};
            w[4:0]   = 5'($urandom_range(0, 3));
            w[15:11] = 5'($urandom_range(0, 3));
            drive(($urandom_range(0, 9) < 7), w, 25'($urandom), 3'($urandom_range(1, 4)));
            ex_ready_i = ($urandom_range(0, 9) < 7);
            flush_i    = ($urandom_range(0, 99) < 3);
            #1;
            acc  = inst_valid_i && inst_ready_o;
            xfer = dec_valid_o && ex_ready_i;
            if (flush_i) begin
                chk("rnd_flush_ready", 96'(inst_ready_o), 96'd0);
            end else if (xfer) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_out", 96'(dec_valid_o), 96'd0);
                end else begin
                    chk("rnd_out", 96'(dut_bundle()), 96'(exp_q[0]));
                end
            end
            stalled   = dec_valid_o && !ex_ready_i;
            snap      = dut_bundle();
            was_flush = flush_i;
            @(posedge clk);
            #1;
            if (was_flush) begin
                exp_q.delete();
            end else begin
                if (xfer && exp_q.size() != 0) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(ref_decode(inst_i, pc_i, inst_len_i));
                if (stalled) begin
                    chk("rnd_hold_valid", 96'(dec_valid_o), 96'd1);
                    chk("rnd_hold_data", 96'(dut_bundle()), 96'(snap));
                end
            end
        end
        chk("rnd_some_transfers", 96'(n_xfer > 100), 96'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
